async_pipe_sink: RTL and testbench

- Clocked receiver at the tail of the self-timed four-phase bundled-data pipeline, e.g. the booth radix partial-product stages.
- Takes the last stage's request and 512-bit data, and returns its acknowledge.
- Synchronizes the request into the clock domain and buffers words in a small FIFO.
- Presents words to synchronous logic over a valid/ready interface.

---
 rtl/async_pipe_sink.sv | 146 ++++++++++++++
 tb/tb_async_pipe_sink.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/async_pipe_sink.sv
// async_pipe_sink
//   Clocked receiver at the tail of a four-phase bundled-data pipeline.
//   The asynchronous request is synchronized into clk. One word is captured
//   per handshake into a small FIFO. The FIFO is drained over valid/ready.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   Rin       in   four-phase request from upstream (asynchronous)
//   Ain       out  four-phase acknowledge to upstream (registered)
//   data_in   in   bundled data, WIDTH bits
//   out_valid out  FIFO non-empty
//   out_ready in   downstream accepts head word
//   out_data  out  FIFO head word, WIDTH bits
//   level     out  FIFO occupancy, $clog2(DEPTH)+1 bits
//   xfer_cnt  out  32-bit count of FIFO writes (only with ASYNC_SINK_XFER_CNT_EN)
//
// Optional feature macro: ASYNC_SINK_XFER_CNT_EN
module async_pipe_sink #(
    parameter int unsigned WIDTH       = 512,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Rin,
    output logic                       Ain,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     level
`ifdef ASYNC_SINK_XFER_CNT_EN
    ,
    output logic [31:0]                xfer_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_req_s;
    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [LW-1:0]          r_level;
    logic                   w_push;
    logic                   w_pop;

    // Only the synchronizer looks at Rin; everything else uses w_req_s.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], Rin};
        end
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Full test uses the level held at the start of the cycle, so a pop in
    // the same cycle does not open room for a push into a full FIFO.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_s && (r_level < DEPTH_L)) begin
                    w_push      = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                if (!w_req_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Single-bit state encoding: Ain is the state flop itself.
    assign Ain = (r_state == ACK);

    assign w_pop = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_in;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign out_valid = (r_level != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign level     = r_level;

`ifdef ASYNC_SINK_XFER_CNT_EN
    logic [31:0] r_xfer_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_xfer_cnt <= '0;
        end else if (w_push) begin
            r_xfer_cnt <= r_xfer_cnt + 32'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_async_pipe_sink.sv
// tb_async_pipe_sink
//   Directed testbench for async_pipe_sink (WIDTH=512, DEPTH=2,
//   SYNC_STAGES=2). Expected values are hand-computed constants.
//   Counter checks are compiled in with ASYNC_SINK_XFER_CNT_EN.
module tb_async_pipe_sink;

    localparam int unsigned WIDTH = 512;

    logic             clk;
    logic             reset;
    logic             Rin;
    logic             Ain;
    logic [WIDTH-1:0] data_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       level;
`ifdef ASYNC_SINK_XFER_CNT_EN
    logic [31:0]      xfer_cnt;
`endif

    int unsigned n_cmp;
    int unsigned n_err;

    async_pipe_sink #(
        .WIDTH(WIDTH),
        .DEPTH(2),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Rin(Rin),
        .Ain(Ain),
        .data_in(data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .level(level)
`ifdef ASYNC_SINK_XFER_CNT_EN
        ,
        .xfer_cnt(xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bounded wait for Ain to reach val; an expired bound shows up as a failed check.
    task automatic wait_ain(input logic val, input string tag);
        int unsigned cnt;
        cnt = 0;
        while (Ain !== val && cnt < 20) begin
            tick(1);
            cnt++;
        end
        check(tag, WIDTH'(Ain), WIDTH'(val));
    endtask

    task automatic handshake(input logic [WIDTH-1:0] d, input string tag);
        data_in = d;
        Rin     = 1'b1;
        wait_ain(1'b1, tag);
        Rin     = 1'b0;
        wait_ain(1'b0, tag);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        Rin       = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;

        #12;
        check("rst_ain",   WIDTH'(Ain),       '0);
        check("rst_valid", WIDTH'(out_valid), '0);
        check("rst_level", WIDTH'(level),     '0);
        check("rst_data",  out_data,          '0);
        tick(1);
        reset = 1'b1;
        tick(1);

        // Single transfer with latency check.
        data_in = 512'hA5A5;
        Rin     = 1'b1;
        tick(2);
        check("single_ain_early", WIDTH'(Ain), '0);
        tick(1);
        check("single_ain",   WIDTH'(Ain),       1);
        check("single_valid", WIDTH'(out_valid), 1);
        check("single_data",  out_data,          512'hA5A5);
        check("single_level", WIDTH'(level),     1);
        Rin = 1'b0;
        tick(2);
        check("single_ain_hold", WIDTH'(Ain), 1);
        tick(1);
        check("single_ain_fall", WIDTH'(Ain), 0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("single_pop_level", WIDTH'(level),     0);
        check("single_pop_valid", WIDTH'(out_valid), 0);

        // Back-pressure: third word stalls until a pop frees a slot.
        handshake(512'd1, "bp_hs1");
        handshake(512'd2, "bp_hs2");
        check("bp_level_full", WIDTH'(level), 2);
        data_in = 512'd3;
        Rin     = 1'b1;
        tick(6);
        check("bp_stall_ain",   WIDTH'(Ain),   0);
        check("bp_stall_level", WIDTH'(level), 2);
        check("bp_head1",       out_data,      512'd1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("bp_pop_level", WIDTH'(level), 1);
        check("bp_pop_ain",   WIDTH'(Ain),   0);
        check("bp_head2",     out_data,      512'd2);
        tick(1);
        check("bp_acc3_ain",   WIDTH'(Ain),   1);
        check("bp_acc3_level", WIDTH'(level), 2);
        Rin = 1'b0;
        wait_ain(1'b0, "bp_hs3_fall");
        check("bp_order2", out_data, 512'd2);
        out_ready = 1'b1;
        tick(1);
        check("bp_order3", out_data, 512'd3);
        tick(1);
        out_ready = 1'b0;
        check("bp_drained", WIDTH'(level), 0);

        // Push and pop on the same edge.
        handshake(512'h11, "pp_hs1");
        check("pp_level_pre", WIDTH'(level), 1);
        data_in = 512'h22;
        Rin     = 1'b1;
        tick(2);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("pp_level", WIDTH'(level), 1);
        check("pp_head",  out_data,      512'h22);
        check("pp_ain",   WIDTH'(Ain),   1);
        Rin = 1'b0;
        wait_ain(1'b0, "pp_fall");
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("pp_drained", WIDTH'(level), 0);

        // Wrap-around: ten words streamed with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = WIDTH'(i);
            Rin     = 1'b1;
            wait_ain(1'b1, "wrap_rise");
            check($sformatf("wrap_data%0d", i), out_data, WIDTH'(i));
            check($sformatf("wrap_lvl%0d", i), WIDTH'(level), 1);
            Rin = 1'b0;
            wait_ain(1'b0, "wrap_fall");
            check($sformatf("wrap_empty%0d", i), WIDTH'(level), 0);
        end
        out_ready = 1'b0;

        // Reset during a handshake with the FIFO full.
        handshake(512'h55, "rm_hs1");
        data_in = 512'h66;
        Rin     = 1'b1;
        wait_ain(1'b1, "rm_rise");
        check("rm_level_pre", WIDTH'(level), 2);
        #2;
        reset = 1'b0;
        #1;
        check("rm_ain",   WIDTH'(Ain),       0);
        check("rm_valid", WIDTH'(out_valid), 0);
        check("rm_level", WIDTH'(level),     0);
        check("rm_data",  out_data,          '0);
        Rin = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(4);
        check("rm_post_ain",   WIDTH'(Ain),   0);
        check("rm_post_level", WIDTH'(level), 0);
        handshake(512'h77, "rm_hs2");
        check("rm_new_level", WIDTH'(level), 1);
        check("rm_new_data",  out_data,      512'h77);

`ifdef ASYNC_SINK_XFER_CNT_EN
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        check("cnt_reset", WIDTH'(xfer_cnt), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            handshake(WIDTH'(i + 1), "cnt_hs");
        end
        check("cnt_five", WIDTH'(xfer_cnt), 5);
        force dut.r_xfer_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_xfer_cnt;
        handshake(512'hA, "cnt_wrap_hs1");
        check("cnt_wrap0", WIDTH'(xfer_cnt), 0);
        handshake(512'hB, "cnt_wrap_hs2");
        check("cnt_wrap1", WIDTH'(xfer_cnt), 1);
        out_ready = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
